// File: rtl/rotate_step_sequencer.sv
// Step sequencer feeding an external 4-bit combinational rotator: latches a start
// pattern, then registers the rotated result back every period+1 cycles for n_steps steps.
//
// state | meaning
// IDLE  | waiting for start; pat_out holds the last published pattern
// WAIT  | counting period ticks, taking one rotate step when tick reaches per
// DONE  | run complete; done strobes in the following cycle, then IDLE
module rotate_step_sequencer #(
  parameter int TICK_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [3:0]        pattern,
  input  logic [1:0]        step,
  input  logic              dir,
  input  logic [3:0]        n_steps,
  input  logic [TICK_W-1:0] period,
  output logic [3:0]        rot_din,
  output logic [1:0]        rot_sh_amt,
  output logic              rot_dir,
  input  logic [3:0]        rot_dout,
  output logic [3:0]        pat_out,
  output logic              pat_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cur_q, cur_d;
  logic [1:0]        amt_q, amt_d;
  logic              dr_q, dr_d;
  logic [3:0]        left_q, left_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [TICK_W-1:0] per_q, per_d;
  logic [3:0]        pat_out_q, pat_out_d;
  logic              pat_valid_q, pat_valid_d;
  logic              done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      amt_q       <= '0;
      dr_q        <= 1'b0;
      left_q      <= '0;
      tick_q      <= '0;
      per_q       <= '0;
      pat_out_q   <= '0;
      pat_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      amt_q       <= amt_d;
      dr_q        <= dr_d;
      left_q      <= left_d;
      tick_q      <= tick_d;
      per_q       <= per_d;
      pat_out_q   <= pat_out_d;
      pat_valid_q <= pat_valid_d;
      done_q      <= done_d;
    end
  end

  // Next state and datapath; stop pre-empts a step due in the same cycle.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    amt_d       = amt_q;
    dr_d        = dr_q;
    left_d      = left_q;
    tick_d      = tick_q;
    per_d       = per_q;
    pat_out_d   = pat_out_q;
    pat_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d   = pattern;
          amt_d   = step;
          dr_d    = dir;
          per_d   = period;
          left_d  = n_steps;
          tick_d  = '0;
          state_d = (n_steps == 4'd0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (tick_q == per_q) begin
          cur_d       = rot_dout;
          pat_out_d   = rot_dout;
          pat_valid_d = 1'b1;
          tick_d      = '0;
          left_d      = left_q - 4'd1;
          if (left_q == 4'd1) state_d = S_DONE;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == S_WAIT);
    rot_din    = cur_q;
    rot_sh_amt = amt_q;
    rot_dir    = dr_q;
    pat_out    = pat_out_q;
    pat_valid  = pat_valid_q;
    done       = done_q;
  end

endmodule
